buff_mc_en: RTL and testbench
=============================

BUFF_MC_EN -- requirements
Module: buff_mc_en

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent input channels, 1..16.
REQ-002 Parameter DEPTH_BUFF, default 8: entries per channel; power of two, >=4.
REQ-003 Parameter THRESH_HI, default 6: occupancy at or above which a channel's back-pressure Nack sets.
REQ-004 Parameter THRESH_LO, default 3: occupancy below which the Nack clears; THRESH_LO < THRESH_HI <= DEPTH_BUFF.
REQ-005 Parameter TYPE_FWRD, default FTk_t: stored forward-token type.
REQ-006 clock  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 I_We  in  NUM_CH  per-channel write enable.
REQ-009 I_FTk  in  NUM_CH x FTk_t  per-channel input token; .v qualifies data.
REQ-010 O_BTk  out  NUM_CH x BTk_t  per-channel back-prop token to producers.
REQ-011 I_Re  in  1  read enable.
REQ-012 I_Sel  in  $clog2(NUM_CH)  channel selected for read.
REQ-013 O_FTk  out  FTk_t  output token, registered.
REQ-014 I_BTk  in  BTk_t  back-prop token from consumer.
REQ-015 O_Empty / O_Full  out  NUM_CH each  per-channel occupancy flags (Num==0 / Num==DEPTH_BUFF).
REQ-016 O_Ovf  out  NUM_CH  sticky flag: write refused because channel full.

Function
REQ-017 Per-channel count Num[c] is $clog2(DEPTH_BUFF)+1 bits wide, range 0..DEPTH_BUFF, never wraps.
REQ-018 Write to c accepted when I_We[c] & I_FTk[c].v & (~O_Full[c] | pop of c in the same cycle).
REQ-019 Write refused while full (no same-cycle pop) sets O_Ovf[c]; it clears only on reset.
REQ-020 Pop when I_Re & state RUN & ~O_Empty[I_Sel]; pops exactly one entry of channel I_Sel, FIFO order.
REQ-021 Popped token appears on O_FTk the cycle after the pop; otherwise O_FTk is '0 that cycle.
REQ-022 Simultaneous push and pop on one channel leaves Num unchanged; pointers wrap modulo DEPTH_BUFF.
REQ-023 O_BTk[c].n is registered: sets the cycle after Num[c] >= THRESH_HI, clears the cycle after Num[c] < THRESH_LO, otherwise holds.
REQ-024 O_BTk[c].t/.v/.c are I_BTk.t/.v/.c passed through combinationally.
REQ-025 Stop FSM states RUN, STOP, RESUME; reset to RUN.
REQ-026 RUN -> STOP when I_BTk.n=1; STOP -> RESUME when I_BTk.n=0; RESUME -> RUN when I_BTk.n=0 again, else -> STOP.
REQ-027 No pop occurs in STOP or RESUME; a single-cycle Nack blocks pops for exactly 2 cycles.
REQ-028 I_Sel out of range (>= NUM_CH) results in no pop.

Reset
REQ-029 Asserting reset (low) at any time, including mid-operation, clears all counts, pointers, O_BTk[].n, O_Ovf, and O_FTk to '0, and sets FSM to RUN.
REQ-030 Storage contents are not reset; O_Empty is 1 and O_Full is 0 for every channel while in reset.

Configuration
REQ-031 With BUFF_MC_BYPASS_EN defined: if channel I_Sel is empty, the FSM is RUN, and I_Re & I_We[I_Sel] & I_FTk[I_Sel].v, the token bypasses storage to O_FTk the next cycle and Num is unchanged.
REQ-032 Without BUFF_MC_BYPASS_EN: reading an empty channel yields no pop and the write is stored normally.

Structure
REQ-033 FTk_t, BTk_t and an enum type for the stop-FSM states live in pkg_en.
REQ-034 Per-channel storage (array, pointers, count) is sub-module buff_mc_ring, instantiated NUM_CH times via generate.

Verification
REQ-035 NUM_CH=4, DEPTH=8: write 8 tokens to ch2, 9th write -> O_Full[2]=1, O_Ovf[2]=1, Num stays 8.
REQ-036 Fill ch0 to 6 -> O_BTk[0].n=1 next cycle; drain to 2 -> .n=0 next cycle; at 4 .n holds 1.
REQ-037 Data 0x11..0x14 on ch1 and 0x21..0x24 on ch3; read with I_Sel alternating 1/3 -> O_FTk = 0x11,0x21,0x12,0x22,... with 1-cycle latency.
REQ-038 I_BTk.n pulsed for one cycle during continuous reads -> exactly 2 cycles with no pop; held 3 cycles -> pops resume 2 cycles after release.
REQ-039 Full channel with simultaneous push and pop -> write accepted, Num stays 8, O_Ovf stays 0.
REQ-040 Reset asserted with 5 entries queued -> all flags clear immediately; after release, O_Empty=all 1 and first read yields no token.

Source files
------------

// File: rtl/buff_mc_en_pkg.sv
// -----------------------------------------------------------------------------
// pkg_en -- shared types for the multi-channel buffer (buff_mc_en).
//   FTk_t     : forward token (valid + data byte) stored per channel.
//   BTk_t     : back-prop token; .n is the Nack, .t/.v/.c are side-band bits.
//   stop_st_t : states of the consumer stop FSM.
// -----------------------------------------------------------------------------
package pkg_en;

  localparam int FTK_DW = 8;

  typedef struct packed {
    logic              v;
    logic [FTK_DW-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic t;
    logic v;
    logic c;
    logic n;
  } BTk_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STOP   = 2'd1,
    ST_RESUME = 2'd2
  } stop_st_t;

endpackage

// File: rtl/buff_mc_ring.sv
// -----------------------------------------------------------------------------
// buff_mc_ring -- one channel's circular store: array, read/write pointers and
// an occupancy count. The parent only asserts push when there is room (or a
// same-cycle pop) and pop when non-empty, so the count never wraps.
// Ports:
//   clock, reset (async, active-low)
//   push / wdata : store wdata at the write pointer
//   pop          : retire the head entry
//   head         : current head entry (combinational read of the array)
//   num          : occupancy 0..DEPTH_BUFF
//   empty / full : num==0 / num==DEPTH_BUFF
// -----------------------------------------------------------------------------
module buff_mc_ring
  import pkg_en::*;
#(
  parameter int  DEPTH_BUFF = 8,
  parameter type TYPE_FWRD  = FTk_t
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  TYPE_FWRD                    wdata,
  input  logic                        pop,
  output TYPE_FWRD                    head,
  output logic [$clog2(DEPTH_BUFF):0] num,
  output logic                        empty,
  output logic                        full
);

  localparam int PTR_W = $clog2(DEPTH_BUFF);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH_BUFF);

  TYPE_FWRD         mem [DEPTH_BUFF];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   num_reg;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= wdata;
  end

  // Power-of-two depth: pointers wrap naturally at their width.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      num_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   num_reg <= num_reg + 1'b1;
        2'b01:   num_reg <= num_reg - 1'b1;
        default: num_reg <= num_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign num   = num_reg;
  assign empty = (num_reg == '0);
  assign full  = (num_reg == FULL_CNT);

endmodule

// File: rtl/buff_mc_en.sv
// -----------------------------------------------------------------------------
// buff_mc_en -- NUM_CH independent FIFO channels sharing one read port.
// Ports:
//   clock, reset (async, active-low)
//   I_We[c], I_FTk[c] : per-channel write; a token is written only when .v=1
//   O_BTk[c]          : .n = registered occupancy hysteresis Nack,
//                       .t/.v/.c = I_BTk side-band passed straight through
//   I_Re, I_Sel       : pop one entry from channel I_Sel
//   O_FTk             : popped token, registered; '0 on cycles with no pop
//   I_BTk             : consumer back-prop; .n drives the RUN/STOP/RESUME FSM
//   O_Empty, O_Full   : per-channel occupancy flags
//   O_Ovf             : sticky per-channel "write refused while full"
// Build option: define BUFF_MC_BYPASS_EN to let a write to an empty channel
// that is being read in the same cycle go straight to O_FTk.
// -----------------------------------------------------------------------------
module buff_mc_en
  import pkg_en::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  DEPTH_BUFF = 8,
  parameter int  THRESH_HI  = 6,
  parameter int  THRESH_LO  = 3,
  parameter type TYPE_FWRD  = FTk_t
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [NUM_CH-1:0]                            I_We,
  input  TYPE_FWRD [NUM_CH-1:0]                        I_FTk,
  output BTk_t [NUM_CH-1:0]                            O_BTk,
  input  logic                                         I_Re,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] I_Sel,
  output TYPE_FWRD                                     O_FTk,
  input  BTk_t                                         I_BTk,
  output logic [NUM_CH-1:0]                            O_Empty,
  output logic [NUM_CH-1:0]                            O_Full,
  output logic [NUM_CH-1:0]                            O_Ovf
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(DEPTH_BUFF) + 1;
  localparam logic [CNT_W-1:0] HI_CNT = CNT_W'(THRESH_HI);
  localparam logic [CNT_W-1:0] LO_CNT = CNT_W'(THRESH_LO);

  stop_st_t          state_reg;
  TYPE_FWRD          o_ftk_reg;
  logic [NUM_CH-1:0] nack_reg;
  logic [NUM_CH-1:0] ovf_reg;

  TYPE_FWRD          head [NUM_CH];
  logic [CNT_W-1:0]  num  [NUM_CH];
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] pop_ch;
  logic [NUM_CH-1:0] push_ch;
  logic [NUM_CH-1:0] wr_req;

  // Selected-channel view. An out-of-range I_Sel matches no channel, so it
  // looks empty with no write: neither a pop nor a bypass can follow.
  logic     sel_empty;
  logic     sel_we;
  TYPE_FWRD sel_head;
  TYPE_FWRD sel_in;

  always_comb begin
    sel_empty = 1'b1;
    sel_we    = 1'b0;
    sel_head  = '0;
    sel_in    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (I_Sel == SEL_W'(c)) begin
        sel_empty = empty[c];
        sel_we    = I_We[c];
        sel_head  = head[c];
        sel_in    = I_FTk[c];
      end
    end
  end

  logic pop_any;
  logic byp;

  assign pop_any = I_Re & (state_reg == ST_RUN) & ~sel_empty;

`ifdef BUFF_MC_BYPASS_EN
  assign byp = I_Re & (state_reg == ST_RUN) & sel_empty & sel_we & sel_in.v;
`else
  assign byp = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign sel_hit[gi] = (I_Sel == SEL_W'(gi));
      assign pop_ch[gi]  = pop_any & sel_hit[gi];
      assign wr_req[gi]  = I_We[gi] & I_FTk[gi].v;
      // A full channel still accepts a write when it is popped this cycle;
      // a bypassed token never enters storage.
      assign push_ch[gi] = wr_req[gi] & (~full[gi] | pop_ch[gi]) & ~(byp & sel_hit[gi]);

      buff_mc_ring #(
        .DEPTH_BUFF (DEPTH_BUFF),
        .TYPE_FWRD  (TYPE_FWRD)
      ) u_ring (
        .clock (clock),
        .reset (reset),
        .push  (push_ch[gi]),
        .wdata (I_FTk[gi]),
        .pop   (pop_ch[gi]),
        .head  (head[gi]),
        .num   (num[gi]),
        .empty (empty[gi]),
        .full  (full[gi])
      );

      // Hysteresis between LO and HI keeps the Nack from chattering.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          nack_reg[gi] <= 1'b0;
        end else if (num[gi] >= HI_CNT) begin
          nack_reg[gi] <= 1'b1;
        end else if (num[gi] < LO_CNT) begin
          nack_reg[gi] <= 1'b0;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          ovf_reg[gi] <= 1'b0;
        end else if (wr_req[gi] & full[gi] & ~pop_ch[gi]) begin
          ovf_reg[gi] <= 1'b1;
        end
      end

      assign O_BTk[gi] = '{t: I_BTk.t, v: I_BTk.v, c: I_BTk.c, n: nack_reg[gi]};
    end
  endgenerate

  // Stop FSM: one Nack cycle costs STOP + RESUME, i.e. two pop-free cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN:    if (I_BTk.n) state_reg <= ST_STOP;
        ST_STOP:   if (!I_BTk.n) state_reg <= ST_RESUME;
        ST_RESUME: state_reg <= I_BTk.n ? ST_STOP : ST_RUN;
        default:   state_reg <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_ftk_reg <= '0;
    end else if (pop_any) begin
      o_ftk_reg <= sel_head;
    end else if (byp) begin
      o_ftk_reg <= sel_in;
    end else begin
      o_ftk_reg <= '0;
    end
  end

  assign O_FTk   = o_ftk_reg;
  assign O_Empty = empty;
  assign O_Full  = full;
  assign O_Ovf   = ovf_reg;

endmodule

// File: tb/tb_buff_mc_en.sv
// -----------------------------------------------------------------------------
// tb_buff_mc_en -- directed bench for buff_mc_en (default build, 4 channels,
// depth 8, thresholds 6/3). Reads push the expected token and its arrival
// cycle into a queue; a monitor on the falling edge pops and compares, and
// requires O_FTk == 0 on every cycle where no token is due.
// -----------------------------------------------------------------------------
module tb_buff_mc_en;
  import pkg_en::*;

  localparam int NUM_CH = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] I_We;
  FTk_t [NUM_CH-1:0] I_FTk;
  BTk_t [NUM_CH-1:0] O_BTk;
  logic              I_Re;
  logic [1:0]        I_Sel;
  FTk_t              O_FTk;
  BTk_t              I_BTk;
  logic [NUM_CH-1:0] O_Empty;
  logic [NUM_CH-1:0] O_Full;
  logic [NUM_CH-1:0] O_Ovf;

  buff_mc_en #(
    .NUM_CH     (NUM_CH),
    .DEPTH_BUFF (8),
    .THRESH_HI  (6),
    .THRESH_LO  (3),
    .TYPE_FWRD  (FTk_t)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .I_We    (I_We),
    .I_FTk   (I_FTk),
    .O_BTk   (O_BTk),
    .I_Re    (I_Re),
    .I_Sel   (I_Sel),
    .O_FTk   (O_FTk),
    .I_BTk   (I_BTk),
    .O_Empty (O_Empty),
    .O_Full  (O_Full),
    .O_Ovf   (O_Ovf)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  function automatic logic [3:0] nack_bits();
    return {O_BTk[3].n, O_BTk[2].n, O_BTk[1].n, O_BTk[0].n};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    I_We  = '0;
    I_FTk = '0;
    I_Re  = 1'b0;
    I_Sel = '0;
    I_BTk = '0;
  endtask

  task automatic wr(input int ch, input logic [7:0] d);
    I_We[ch]  = 1'b1;
    I_FTk[ch] = '{v: 1'b1, d: d};
  endtask

  // Issue a read of channel ch whose token d must show one cycle later.
  task automatic rd_exp(input int ch, input logic [7:0] d);
    exp_t e;
    I_Re  = 1'b1;
    I_Sel = 2'(ch);
    e.d   = d;
    e.cyc = cyc + 1;
    sbq.push_back(e);
  endtask

  // Monitor: compare whatever is due this cycle, otherwise demand zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        checks++;
        failures++;
        $display("FAIL o_ftk_missing: got nothing expected 0x%0h at cycle %0d", e.d, e.cyc);
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        chk("o_ftk", 32'(O_FTk), {23'b0, 1'b1, e.d});
      end else begin
        chk("o_ftk_idle", 32'(O_FTk), 32'h0);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  logic [11:0] nack_pat;
  logic [11:0] pop_pat;

  initial begin
    int k;
    idle();
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_empty", 32'(O_Empty), 32'hF);
    chk("rst_full",  32'(O_Full),  32'h0);
    chk("rst_ovf",   32'(O_Ovf),   32'h0);
    chk("rst_nack",  32'(nack_bits()), 32'h0);
    reset = 1'b1;
    tick();

    // Overflow on ch2: eight accepted, ninth refused and flagged.
    for (int i = 0; i < 8; i++) begin
      idle(); wr(2, 8'h40 + 8'(i)); tick();
    end
    idle();
    chk("full_ch2", 32'(O_Full), 32'h4);
    wr(2, 8'h99); tick(); idle();
    chk("ovf_ch2", 32'(O_Ovf), 32'h4);
    chk("full_ch2_after_ovf", 32'(O_Full), 32'h4);
    for (int i = 0; i < 8; i++) begin
      idle(); rd_exp(2, 8'h40 + 8'(i)); tick();
    end
    idle();
    chk("empty_ch2_drained", 32'(O_Empty[2]), 32'h1);
    tick();

    // Full ch1 with push and pop in the same cycle.
    for (int i = 0; i < 8; i++) begin
      idle(); wr(1, 8'h50 + 8'(i)); tick();
    end
    idle(); wr(1, 8'h58); rd_exp(1, 8'h50); tick(); idle();
    chk("full_ch1_pushpop", 32'(O_Full), 32'h2);
    chk("ovf_ch1_pushpop",  32'(O_Ovf),  32'h4);
    for (int i = 1; i < 9; i++) begin
      idle(); rd_exp(1, 8'h50 + 8'(i)); tick();
    end
    idle();
    chk("empty_ch1_drained", 32'(O_Empty[1]), 32'h1);

    // Nack hysteresis on ch0.
    for (int i = 0; i < 6; i++) begin
      idle(); wr(0, 8'(i + 1)); tick();
      if (i >= 4) chk("nack0_not_yet", 32'(nack_bits()), 32'h0);
    end
    idle(); tick();
    chk("nack0_set", 32'(nack_bits()), 32'h1);
    idle(); rd_exp(0, 8'h01); tick();
    idle(); rd_exp(0, 8'h02); tick();
    idle(); tick();
    chk("nack0_hold_at4", 32'(nack_bits()), 32'h1);
    idle(); rd_exp(0, 8'h03); tick();
    idle(); rd_exp(0, 8'h04); tick();
    chk("nack0_hold_at3", 32'(nack_bits()), 32'h1);
    idle(); tick();
    chk("nack0_clear", 32'(nack_bits()), 32'h0);
    idle(); rd_exp(0, 8'h05); tick();
    idle(); rd_exp(0, 8'h06); tick();

    // Interleaved reads from ch1 and ch3.
    for (int i = 0; i < 4; i++) begin
      idle(); wr(1, 8'h11 + 8'(i)); wr(3, 8'h21 + 8'(i)); tick();
    end
    for (int i = 0; i < 4; i++) begin
      idle(); rd_exp(1, 8'h11 + 8'(i)); tick();
      idle(); rd_exp(3, 8'h21 + 8'(i)); tick();
    end

    // Side-band pass-through.
    idle();
    I_BTk = '{t: 1'b1, v: 1'b0, c: 1'b1, n: 1'b0};
    #1;
    chk("btk2_tvc", {29'b0, O_BTk[2].t, O_BTk[2].v, O_BTk[2].c}, 32'h5);
    I_BTk = '{t: 1'b0, v: 1'b1, c: 1'b0, n: 1'b0};
    #1;
    chk("btk0_tvc", {29'b0, O_BTk[0].t, O_BTk[0].v, O_BTk[0].c}, 32'h2);
    tick();

    // Consumer Nack during continuous reads of ch0: 1-cycle pulse, then 3-cycle hold.
    for (int i = 0; i < 8; i++) begin
      idle(); wr(0, 8'h80 + 8'(i)); tick();
    end
    nack_pat = 12'h0E2;
    pop_pat  = 12'hC33;
    k = 0;
    for (int j = 0; j < 12; j++) begin
      idle();
      I_Re    = 1'b1;
      I_Sel   = 2'd0;
      I_BTk.n = nack_pat[j];
      if (pop_pat[j]) begin
        rd_exp(0, 8'h80 + 8'(k));
        k++;
      end
      tick();
    end
    while (k < 8) begin
      idle(); rd_exp(0, 8'h80 + 8'(k)); k++; tick();
    end
    idle();
    chk("empty_ch0_after_stall", 32'(O_Empty[0]), 32'h1);

    // Read of an empty channel with a same-cycle write: no output, write stored.
    idle(); wr(3, 8'h33); I_Re = 1'b1; I_Sel = 2'd3; tick(); idle();
    chk("empty_rd_stores", 32'(O_Empty[3]), 32'h0);
    rd_exp(3, 8'h33); tick(); idle(); tick();
    chk("empty_ch3", 32'(O_Empty[3]), 32'h1);

    // Reset mid-operation with 5 entries queued on ch2 and a token on O_FTk.
    for (int i = 0; i < 5; i++) begin
      idle(); wr(2, 8'h60 + 8'(i)); tick();
    end
    idle(); rd_exp(2, 8'h60); tick(); idle();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(O_Empty), 32'hF);
    chk("mid_rst_full",  32'(O_Full),  32'h0);
    chk("mid_rst_ovf",   32'(O_Ovf),   32'h0);
    chk("mid_rst_nack",  32'(nack_bits()), 32'h0);
    chk("mid_rst_ftk",   32'(O_FTk),   32'h0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    tick();
    chk("post_rst_empty", 32'(O_Empty), 32'hF);
    I_Re = 1'b1; I_Sel = 2'd2; tick(); idle();
    chk("post_rst_no_token", 32'(O_FTk), 32'h0);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
